dual_port_inorder_queue: RTL

DUAL_PORT_INORDER_QUEUE -- requirements
Module: dual_port_inorder_queue

---
 rtl/dual_port_inorder_queue_pkg.sv | 48 ++++
 rtl/dual_port_inorder_queue_if.sv | 44 ++++
 rtl/dual_port_inorder_queue_storage.sv | 28 ++
 rtl/dual_port_inorder_queue.sv | 102 ++++++++++
 4 files changed

// File: rtl/dual_port_inorder_queue_pkg.sv
// Shared out-of-order payload layout plus small helpers for the in-order queue.
// The queue itself treats the payload as opaque; only its total width matters here.
package dual_port_inorder_queue_pkg;

  localparam int FORMAT_W    = 4;
  localparam int OPCODE_W    = 8;
  localparam int ADDRESS_W   = 32;
  localparam int FUNC_UNIT_W = 4;
  localparam int MAJ_ID_W    = 8;
  localparam int MIN_ID_W    = 8;
  localparam int PID_W       = 4;
  localparam int TID_W       = 4;
  localparam int OPERAND_W   = 32;
  localparam int BODY_W      = 88;

  localparam int PAYLOAD_WIDTH = FORMAT_W + OPCODE_W + ADDRESS_W + FUNC_UNIT_W + MAJ_ID_W
                               + MIN_ID_W + PID_W + TID_W + 3 * OPERAND_W + BODY_W;

  typedef enum logic [FUNC_UNIT_W-1:0] {
    FU_ALU  = 4'd0,
    FU_MUL  = 4'd1,
    FU_LSU  = 4'd2,
    FU_BRU  = 4'd3
  } func_unit_e;

  // Field order is MSB first; offsets follow from the packed struct layout.
  typedef struct packed {
    logic [FORMAT_W-1:0]  format;
    logic [OPCODE_W-1:0]  opcode;
    logic [ADDRESS_W-1:0] address;
    func_unit_e           func_unit;
    logic [MAJ_ID_W-1:0]  maj_id;
    logic [MIN_ID_W-1:0]  min_id;
    logic [PID_W-1:0]     pid;
    logic [TID_W-1:0]     tid;
    logic [OPERAND_W-1:0] operand0;
    logic [OPERAND_W-1:0] operand1;
    logic [OPERAND_W-1:0] operand2;
    logic [BODY_W-1:0]    body;
  } payload_t;

  localparam int OPCODE_OFFSET = PAYLOAD_WIDTH - FORMAT_W - OPCODE_W;

  function automatic logic [OPCODE_W-1:0] payload_opcode(input payload_t p);
    return p.opcode;
  endfunction

endpackage

// File: rtl/dual_port_inorder_queue_if.sv
// Request/response bundle of the dual-port in-order queue.
interface dual_port_inorder_queue_if
  import dual_port_inorder_queue_pkg::*;
#(
  parameter int queueIndexBits = 3,
  parameter int entryWidth     = PAYLOAD_WIDTH
);
  // Requests are single-cycle strobes sampled on the rising edge, slot 0 older/head.
  // Slot 1 is only honoured together with slot 0; a request the queue cannot satisfy
  // in full is dropped whole and reported through the sticky overflow/underflow flags.
  logic                      flush_i;
  logic                      writeEnable0_i;
  logic                      writeEnable1_i;
  logic [entryWidth-1:0]     entry0_i;
  logic [entryWidth-1:0]     entry1_i;
  logic                      readEnable0_i;
  logic                      readEnable1_i;
  logic [entryWidth-1:0]     entry0_o;
  logic [entryWidth-1:0]     entry1_o;
  logic                      valid0_o;
  logic                      valid1_o;
  logic [queueIndexBits-1:0] head_o;
  logic [queueIndexBits-1:0] tail_o;
  logic [queueIndexBits:0]   count_o;
  logic                      isEmpty_o;
  logic                      isFull_o;
  logic                      almostFull_o;
  logic                      overflow_o;
  logic                      underflow_o;

  modport master (
    output flush_i, writeEnable0_i, writeEnable1_i, entry0_i, entry1_i,
           readEnable0_i, readEnable1_i,
    input  entry0_o, entry1_o, valid0_o, valid1_o, head_o, tail_o, count_o,
           isEmpty_o, isFull_o, almostFull_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, writeEnable0_i, writeEnable1_i, entry0_i, entry1_i,
           readEnable0_i, readEnable1_i,
    output entry0_o, entry1_o, valid0_o, valid1_o, head_o, tail_o, count_o,
           isEmpty_o, isFull_o, almostFull_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/dual_port_inorder_queue_storage.sv
// Two-write / two-read payload array; writes on the rising edge, reads combinational.
module queue_storage_2w2r #(
  parameter int IDX_BITS = 3,
  parameter int WIDTH    = 256
) (
  input  logic                clk,
  input  logic                we0,
  input  logic                we1,
  input  logic [IDX_BITS-1:0] waddr0,
  input  logic [IDX_BITS-1:0] waddr1,
  input  logic [WIDTH-1:0]    wdata0,
  input  logic [WIDTH-1:0]    wdata1,
  input  logic [IDX_BITS-1:0] raddr0,
  input  logic [IDX_BITS-1:0] raddr1,
  output logic [WIDTH-1:0]    rdata0,
  output logic [WIDTH-1:0]    rdata1
);
  logic [WIDTH-1:0] mem [2**IDX_BITS];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/dual_port_inorder_queue.sv
// In-order queue accepting up to two enqueues and two dequeues per cycle.
// Pointer/count control lives here; payload storage is in queue_storage_2w2r.
module dual_port_inorder_queue
  import dual_port_inorder_queue_pkg::*;
#(
  parameter int queueIndexBits  = 3,
  parameter int entryWidth      = PAYLOAD_WIDTH,
  parameter int almostFullSlack = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  dual_port_inorder_queue_if.slave q
);
  typedef logic [queueIndexBits-1:0] ptr_t;
  typedef logic [queueIndexBits:0]   cnt_t;

  localparam cnt_t DEPTH   = {1'b1, {queueIndexBits{1'b0}}};
  localparam cnt_t CNT_ONE = {{queueIndexBits{1'b0}}, 1'b1};
  localparam cnt_t CNT_TWO = CNT_ONE << 1;
  localparam cnt_t SLACK   = almostFullSlack[queueIndexBits:0];

  ptr_t head, tail;
  cnt_t count;
  logic overflow, underflow;

  cnt_t free_slots, wr_req, rd_req, wr_acc, rd_acc;
  logic wr_bad, rd_bad, wr_fits, rd_fits;
  logic we0_acc, we1_acc, rd0_acc, rd1_acc;
  logic wr_reject, rd_reject;

  always_comb begin
    free_slots = DEPTH - count;
    wr_bad     = q.writeEnable1_i & ~q.writeEnable0_i;
    rd_bad     = q.readEnable1_i & ~q.readEnable0_i;
    wr_req     = '0;
    rd_req     = '0;
    if (q.writeEnable0_i) wr_req = q.writeEnable1_i ? CNT_TWO : CNT_ONE;
    if (q.readEnable0_i)  rd_req = q.readEnable1_i ? CNT_TWO : CNT_ONE;
    // Space and occupancy are judged at cycle start: a same-cycle read frees nothing.
    wr_fits   = (wr_req <= free_slots);
    rd_fits   = (rd_req <= count);
    we0_acc   = ~q.flush_i & q.writeEnable0_i & wr_fits;
    we1_acc   = we0_acc & q.writeEnable1_i;
    rd0_acc   = ~q.flush_i & q.readEnable0_i & rd_fits;
    rd1_acc   = rd0_acc & q.readEnable1_i;
    wr_reject = ~q.flush_i & (wr_bad | ~wr_fits);
    rd_reject = ~q.flush_i & (rd_bad | ~rd_fits);
    wr_acc    = '0;
    rd_acc    = '0;
    if (we0_acc) wr_acc = we1_acc ? CNT_TWO : CNT_ONE;
    if (rd0_acc) rd_acc = rd1_acc ? CNT_TWO : CNT_ONE;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (q.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head      <= head + ptr_t'(rd_acc);
      tail      <= tail + ptr_t'(wr_acc);
      count     <= count + wr_acc - rd_acc;
      overflow  <= overflow | wr_reject;
      underflow <= underflow | rd_reject;
    end
  end

  // Storage has no reset, so writes are held off while reset is asserted.
  queue_storage_2w2r #(
    .IDX_BITS (queueIndexBits),
    .WIDTH    (entryWidth)
  ) u_storage (
    .clk    (clock_i),
    .we0    (we0_acc & ~reset_i),
    .we1    (we1_acc & ~reset_i),
    .waddr0 (tail),
    .waddr1 (tail + ptr_t'(1)),
    .wdata0 (q.entry0_i),
    .wdata1 (q.entry1_i),
    .raddr0 (head),
    .raddr1 (head + ptr_t'(1)),
    .rdata0 (q.entry0_o),
    .rdata1 (q.entry1_o)
  );

  assign q.head_o       = head;
  assign q.tail_o       = tail;
  assign q.count_o      = count;
  assign q.valid0_o     = (count >= CNT_ONE);
  assign q.valid1_o     = (count >= CNT_TWO);
  assign q.isEmpty_o    = (count == '0);
  assign q.isFull_o     = (count == DEPTH);
  assign q.almostFull_o = (free_slots <= SLACK);
  assign q.overflow_o   = overflow;
  assign q.underflow_o  = underflow;
endmodule
